sort_job_scheduler: RTL and testbench

Job-level sequencer for the 4-lane sorting datapath and its input/output buffers. It accepts a queue of sort-job descriptors (beat count plus tag) and runs each job in turn. For each job it drives the datapath's beat/start/writeback controls, waits for sort completion and for the last result beat to leave the AXIS master, then reports a completion. It sits between the AXI-Lite register block (descriptor source) and the sorting datapath control inputs.

---
 rtl/sort_pkg.sv | 21 ++
 rtl/sort_job_scheduler_if.sv | 33 +++
 rtl/sort_desc_fifo.sv | 59 +++++
 rtl/sort_job_scheduler.sv | 149 ++++++++++++++
 tb/tb_sort_job_scheduler.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and constants for the sort job scheduler
package sort_pkg;
  localparam int WRDW     = 32;
  localparam int WRDN     = 4;
  localparam int BEATW    = 20;
  localparam int TAGW     = 8;
  localparam int MIN_BEAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SORT  = 3'd2,
    ST_WB    = 3'd3,
    ST_DRAIN = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [BEATW-1:0] beat;
    logic [TAGW-1:0]  tag;
  } sort_desc_t;
endpackage

// File: rtl/sort_job_scheduler_if.sv
// rtl/sort_job_scheduler_if.sv - descriptor, datapath-control and completion signals
interface sort_job_scheduler_if #(
  parameter int BEATW = 20,
  parameter int TAGW  = 8
);
  logic             i_desc_valid;
  logic [BEATW-1:0] i_desc_beat;
  logic [TAGW-1:0]  i_desc_tag;
  logic             o_desc_ready;
  logic             o_desc_err;
  logic [BEATW-1:0] o_beat;
  logic             o_start;
  logic             i_done;
  logic             o_writeback;
  logic             i_wb_last;
  logic             o_cpl_valid;
  logic [TAGW-1:0]  o_cpl_tag;
  logic             o_busy;
  logic [15:0]      o_jobs_done;
  logic             o_timeout;

  modport master (
    input  i_desc_valid, i_desc_beat, i_desc_tag, i_done, i_wb_last,
    output o_desc_ready, o_desc_err, o_beat, o_start, o_writeback,
           o_cpl_valid, o_cpl_tag, o_busy, o_jobs_done, o_timeout
  );

  modport slave (
    output i_desc_valid, i_desc_beat, i_desc_tag, i_done, i_wb_last,
    input  o_desc_ready, o_desc_err, o_beat, o_start, o_writeback,
           o_cpl_valid, o_cpl_tag, o_busy, o_jobs_done, o_timeout
  );
endinterface

// File: rtl/sort_desc_fifo.sv
// rtl/sort_desc_fifo.sv - register-based descriptor FIFO with simultaneous push/pop
module sort_desc_fifo #(
  parameter int DW = 28,
  parameter int AW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_rdata = mem_q[rptr_q];
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = i_wdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/sort_job_scheduler.sv
// rtl/sort_job_scheduler.sv - serialises sort jobs onto the datapath start/writeback controls
module sort_job_scheduler #(
    parameter int BEATW        = 20,
    parameter int BUFD_ORDER   = 19,
    parameter int QDEPTH_ORDER = 2,
    parameter int TAGW         = 8,
    parameter int TMO_W        = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_desc_valid,
    input  logic [BEATW-1:0] i_desc_beat,
    input  logic [TAGW-1:0]  i_desc_tag,
    output logic             o_desc_ready,
    output logic             o_desc_err,
    output logic [BEATW-1:0] o_beat,
    output logic             o_start,
    input  logic             i_done,
    output logic             o_writeback,
    input  logic             i_wb_last,
    output logic             o_cpl_valid,
    output logic [TAGW-1:0]  o_cpl_tag,
    output logic             o_busy,
    output logic [15:0]      o_jobs_done,
    output logic             o_timeout
);
    import sort_pkg::*;

    localparam logic [BEATW:0] MAX_BEAT = {{BEATW{1'b0}}, 1'b1} << BUFD_ORDER;

    sched_state_e          state_q, state_d;
    logic [BEATW-1:0]      beat_q, beat_d;
    logic [TAGW-1:0]       tag_q, tag_d;
    logic                  cpl_q, cpl_d;
    logic                  err_q, err_d;
    logic [15:0]           jobs_q, jobs_d;
    logic                  fifo_full, fifo_empty, push, pop, legal, tmo_hit;
    logic [BEATW+TAGW-1:0] head;

    assign legal = (i_desc_beat >= BEATW'(MIN_BEAT)) && ({1'b0, i_desc_beat} <= MAX_BEAT);
    assign push  = i_desc_valid && !fifo_full && legal;
    assign pop   = (state_q == ST_IDLE) && !fifo_empty;

    sort_desc_fifo #(.DW(BEATW + TAGW), .AW(QDEPTH_ORDER)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_wdata ({i_desc_beat, i_desc_tag}),
        .i_pop   (pop),
        .o_rdata (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tag_d   = tag_q;
        cpl_d   = 1'b0;
        jobs_d  = jobs_q;
        err_d   = i_desc_valid && !fifo_full && !legal;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    {beat_d, tag_d} = head;
                    state_d         = ST_START;
                end
            end
            ST_START: state_d = ST_SORT;
            ST_SORT: begin
                if (tmo_hit) begin
                    cpl_d   = 1'b1;
                    jobs_d  = jobs_q + 16'd1;
                    state_d = ST_IDLE;
                end else if (i_done) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (i_wb_last || tmo_hit) begin
                    cpl_d   = 1'b1;
                    jobs_d  = jobs_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            tag_q   <= '0;
            cpl_q   <= 1'b0;
            err_q   <= 1'b0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tag_q   <= tag_d;
            cpl_q   <= cpl_d;
            err_q   <= err_d;
            jobs_q  <= jobs_d;
        end
    end

`ifdef SORT_SCHED_WATCHDOG_EN
    logic [TMO_W-1:0] wdog_q, wdog_d;
    logic             tmo_q, tmo_d;
    logic             waiting;

    assign waiting = (state_q == ST_SORT) || (state_q == ST_DRAIN);
    assign tmo_hit = waiting && (&wdog_q);

    always_comb begin
        wdog_d = wdog_q;
        if (state_d != state_q) wdog_d = '0;
        else if (waiting)       wdog_d = wdog_q + 1'b1;
        tmo_d = tmo_q || tmo_hit;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdog_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            tmo_q  <= tmo_d;
        end
    end

    assign o_timeout = tmo_q;
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_desc_ready = !fifo_full;
    assign o_desc_err   = err_q;
    assign o_beat       = beat_q;
    assign o_start      = (state_q == ST_START);
    assign o_writeback  = (state_q == ST_WB);
    assign o_cpl_valid  = cpl_q;
    assign o_cpl_tag    = tag_q;
    assign o_busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign o_jobs_done  = jobs_q;
endmodule

// File: tb/tb_sort_job_scheduler.sv
// tb/tb_sort_job_scheduler.sv - scoreboard bench for sort_job_scheduler
module tb_sort_job_scheduler;
    import sort_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sort_job_scheduler_if #(.BEATW(20), .TAGW(8)) bus ();

    sort_job_scheduler #(.BEATW(20), .BUFD_ORDER(19), .QDEPTH_ORDER(2), .TAGW(8), .TMO_W(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_desc_valid (bus.i_desc_valid),
        .i_desc_beat  (bus.i_desc_beat),
        .i_desc_tag   (bus.i_desc_tag),
        .o_desc_ready (bus.o_desc_ready),
        .o_desc_err   (bus.o_desc_err),
        .o_beat       (bus.o_beat),
        .o_start      (bus.o_start),
        .i_done       (bus.i_done),
        .o_writeback  (bus.o_writeback),
        .i_wb_last    (bus.i_wb_last),
        .o_cpl_valid  (bus.o_cpl_valid),
        .o_cpl_tag    (bus.o_cpl_tag),
        .o_busy       (bus.o_busy),
        .o_jobs_done  (bus.o_jobs_done),
        .o_timeout    (bus.o_timeout)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    sort_desc_t pend_q[$];
    sort_desc_t fly_q[$];
    int  done_model = 0;
    int  err_exp = 0, err_seen = 0, start_cnt = 0;
    int  last_wb_cyc = -100;
    bit  dp_auto = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        sort_desc_t d;
        if (rst_n) begin
            if (bus.o_start) begin
                start_cnt++;
                chk("start_serial", fly_q.size(), 0);
                if (pend_q.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    d = pend_q.pop_front();
                    chk("start_beat", bus.o_beat, d.beat);
                    chk("start_gap", (cyc - last_wb_cyc) >= 2, 1);
                    fly_q.push_back(d);
                end
            end
            if (bus.o_cpl_valid) begin
                if (fly_q.size() == 0) chk("cpl_unexpected", 1, 0);
                else begin
                    d = fly_q.pop_front();
                    done_model++;
                    chk("cpl_tag", bus.o_cpl_tag, d.tag);
                    chk("jobs_done", bus.o_jobs_done, done_model & 16'hffff);
                end
            end
            if (bus.o_desc_err) err_seen++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (dp_auto && rst_n && bus.o_start) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1 bus.i_done = 1'b1;
            @(posedge clk); #1 bus.i_done = 1'b0;
            @(negedge clk);
            chk("wb_after_done", bus.o_writeback, 1);
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1 bus.i_wb_last = 1'b1;
            last_wb_cyc = cyc;
            @(posedge clk); #1 bus.i_wb_last = 1'b0;
        end
    end

    task automatic push(input int beat, input int tag, output bit acc);
        sort_desc_t d;
        bus.i_desc_valid = 1'b1;
        bus.i_desc_beat  = 20'(beat);
        bus.i_desc_tag   = 8'(tag);
        @(negedge clk);
        acc = bus.o_desc_ready;
        if (acc) begin
            if (beat >= 2 && beat <= (1 << 19)) begin
                d.beat = 20'(beat);
                d.tag  = 8'(tag);
                pend_q.push_back(d);
            end else err_exp++;
        end
        @(posedge clk); #1;
        bus.i_desc_valid = 1'b0;
    endtask

    task automatic finish_job();
        bus.i_done = 1'b1;
        @(posedge clk); #1 bus.i_done = 1'b0;
        @(posedge clk); #1 bus.i_wb_last = 1'b1;
        last_wb_cyc = cyc;
        @(posedge clk); #1 bus.i_wb_last = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((bus.o_busy || fly_q.size() != 0 || pend_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n < budget, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, bus.o_desc_ready, 1);
        chk({tag, "_start"}, bus.o_start, 0);
        chk({tag, "_wb"}, bus.o_writeback, 0);
        chk({tag, "_cpl"}, bus.o_cpl_valid, 0);
        chk({tag, "_cpl_tag"}, bus.o_cpl_tag, 0);
        chk({tag, "_beat"}, bus.o_beat, 0);
        chk({tag, "_busy"}, bus.o_busy, 0);
        chk({tag, "_jobs"}, bus.o_jobs_done, 0);
        chk({tag, "_err"}, bus.o_desc_err, 0);
        chk({tag, "_tmo"}, bus.o_timeout, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got %0d want done", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        bit acc;
        int b, s0;
        bus.i_desc_valid = 1'b0;
        bus.i_desc_beat  = '0;
        bus.i_desc_tag   = '0;
        bus.i_done       = 1'b0;
        bus.i_wb_last    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1 rst_n = 1'b1;

        while (cyc < 10) @(posedge clk);
        #1;
        push(8, 8'h11, acc);
        chk("single_acc", acc, 1);
        @(negedge clk); chk("start_early", bus.o_start, 0);
        @(negedge clk); chk("start_latency", bus.o_start, 1);
        chk("busy_job", bus.o_busy, 1);
        repeat (20) @(posedge clk);
        #1 finish_job();
        @(negedge clk);
        chk("single_cpl", bus.o_cpl_valid, 1);
        chk("single_tag", bus.o_cpl_tag, 8'h11);
        chk("single_jobs", bus.o_jobs_done, 1);
        @(posedge clk); #1;
        wait_idle("single_idle", 50);

        push(6, 8'hA0, acc);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) begin
            push(4 + i, i, acc);
            chk($sformatf("qfull_ready_%0d", i), acc, i <= 4);
        end
        dp_auto = 1'b1;
        finish_job();
        wait_idle("qfull_idle", 400);

        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 0 : (i == 1) ? 1 : (1 << 19) + 1;
            push(b, 8'hE0 + i, acc);
            @(negedge clk);
            chk($sformatf("illegal_err_%0d", i), bus.o_desc_err, 1);
            chk($sformatf("illegal_busy_%0d", i), bus.o_busy, 0);
            @(posedge clk); #1;
        end
        push(2, 8'h22, acc);
        chk("beat_min_acc", acc, 1);
        push(1 << 19, 8'h23, acc);
        chk("beat_max_acc", acc, 1);
        @(negedge clk); chk("legal_no_err", bus.o_desc_err, 0);
        @(posedge clk); #1;
        wait_idle("legal_idle", 200);

        dp_auto = 1'b0;
        push(16, 8'h55, acc);
        repeat (2) @(posedge clk);
        #1 bus.i_wb_last = 1'b1;
        @(posedge clk); #1 bus.i_wb_last = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("spur_wb_cpl", bus.o_cpl_valid, 0);
            chk("spur_wb_wbk", bus.o_writeback, 0);
        end
        @(posedge clk); #1 bus.i_done = 1'b1;
        @(posedge clk); #1 bus.i_done = 1'b0;
        @(posedge clk); #1 bus.i_done = 1'b1;
        @(posedge clk); #1 bus.i_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("spur_done_cpl", bus.o_cpl_valid, 0);
            chk("spur_done_wbk", bus.o_writeback, 0);
        end
        @(posedge clk); #1 bus.i_wb_last = 1'b1;
        last_wb_cyc = cyc;
        @(posedge clk); #1 bus.i_wb_last = 1'b0;
        wait_idle("spur_idle", 50);

        push(10, 8'h61, acc);
        push(11, 8'h62, acc);
        push(12, 8'h63, acc);
        @(posedge clk); #1;
        finish_job();
        bus.i_done = 1'b0;
        @(posedge clk); #1 bus.i_done = 1'b1;
        @(posedge clk); #1 bus.i_done = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        pend_q.delete();
        fly_q.delete();
        done_model = 0;
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        s0 = start_cnt;
        repeat (20) @(posedge clk);
        #1 chk("no_start_after_rst", start_cnt - s0, 0);
        dp_auto = 1'b1;
        push(9, 8'h70, acc);
        wait_idle("postrst_idle", 100);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 9))
                    0: b = 0;
                    1: b = 1;
                    2: b = 2;
                    3: b = 1 << 19;
                    4: b = (1 << 19) + 1;
                    default: b = $urandom_range(3, 5000);
                endcase
                push(b, $urandom_range(0, 255), acc);
            end else begin
                @(posedge clk); #1;
            end
        end
        wait_idle("rand_idle", 4000);
        repeat (2) @(posedge clk);
        chk("err_count", err_seen, err_exp);

`ifdef SORT_SCHED_WATCHDOG_EN
        dp_auto = 1'b0;
        #1 s0 = done_model;
        push(5, 8'h99, acc);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("wdog_tmo", bus.o_timeout, 1);
        chk("wdog_cpl", done_model - s0, 1);
        chk("wdog_idle", bus.o_busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
